alu_control_seq: RTL

//  Registered, parametrised successor to the combinational ALU decoder. Decodes opcode/funct

---
 rtl/alu_ctrl_pkg.sv | 42 ++++
 rtl/alu_decode_comb.sv | 57 +++++
 rtl/alu_control_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings, instruction field values and sequencer state for alu_control_seq.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MULT = 4'b1101;
    localparam logic [3:0] ALU_DIV  = 4'b1110;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational opcode/funct decoder: ALU control code, illegal flag and multi-cycle qualifiers.
module alu_decode_comb
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W = 4
) (
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    output logic [CTRL_W-1:0] alu_control,
    output logic              illegal,
    output logic              is_md,
    output logic              is_div
);

    logic [3:0] code;

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        code    = ALU_ADD;
        illegal = 1'b0;
        is_md   = 1'b0;
        is_div  = 1'b0;
        case (opcode)
            OP_BEQ:   code = ALU_SUB;
            OP_SLTI:  code = ALU_SLT;
            OP_ADDI:  code = ALU_ADD;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  code = ALU_ADD;
                    FN_SUB:  code = ALU_SUB;
                    FN_AND:  code = ALU_AND;
                    FN_OR:   code = ALU_OR;
                    FN_XOR:  code = ALU_XOR;
                    FN_NOR:  code = ALU_NOR;
                    FN_SLT:  code = ALU_SLT;
                    FN_SLL:  code = ALU_SLL;
                    FN_SRL:  code = ALU_SRL;
                    FN_MULT: begin
                        code  = ALU_MULT;
                        is_md = 1'b1;
                    end
                    FN_DIV: begin
                        code   = ALU_DIV;
                        is_md  = 1'b1;
                        is_div = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            // Non-R-type opcodes other than the three above fall back to ADD, not illegal.
            default: code = ALU_ADD;
        endcase
    end

    assign alu_control = CTRL_W'(code);

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU decoder with a multiply/divide sequencer: latency counter, start/done pulses, stall.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int INSTR_W  = 32,
    parameter int CTRL_W   = 4,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               flush,
    output logic               out_valid,
    output logic [CTRL_W-1:0]  alu_control,
    output logic               illegal,
    output logic               md_start,
    output logic               md_is_div,
    output logic               md_busy,
    output logic               md_done,
    output logic               stall
);

    localparam int CNT_W = $clog2(max_int(MULT_LAT, DIV_LAT) + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] alu_control_q, alu_control_d;
    logic              illegal_q, illegal_d;
    logic              md_start_q, md_start_d;
    logic              md_is_div_q, md_is_div_d;
    logic              md_done_q, md_done_d;

    logic [CTRL_W-1:0] dec_control;
    logic              dec_illegal;
    logic              dec_is_md;
    logic              dec_is_div;
    logic              accept;

    alu_decode_comb #(
        .CTRL_W (CTRL_W)
    ) u_decode (
        .opcode      (instruction[INSTR_W-1 -: 6]),
        .funct       (instruction[5:0]),
        .alu_control (dec_control),
        .illegal     (dec_illegal),
        .is_md       (dec_is_md),
        .is_div      (dec_is_div)
    );

    // Immediate/register fields between opcode and funct play no part in ALU control.
    generate
        if (INSTR_W > 12) begin : g_unused_mid
            logic unused_mid_bits;
            assign unused_mid_bits = ^instruction[INSTR_W-7:6];
        end
    endgenerate

    assign stall   = (state_q == S_BUSY);
    assign md_busy = stall;
    assign accept  = in_valid && !stall && !flush;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        out_valid_d   = accept;
        alu_control_d = alu_control_q;
        illegal_d     = illegal_q;
        md_start_d    = 1'b0;
        md_is_div_d   = md_is_div_q;
        md_done_d     = 1'b0;

        if (accept) begin
            alu_control_d = dec_control;
            illegal_d     = dec_illegal;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && dec_is_md) begin
                    state_d     = S_BUSY;
                    md_start_d  = 1'b1;
                    md_is_div_d = dec_is_div;
                    cnt_d       = dec_is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            S_BUSY: begin
                // Flush wins over a completion landing in the same cycle: no done pulse.
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d   = S_IDLE;
                    md_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            alu_control_q <= '0;
            illegal_q     <= 1'b0;
            md_start_q    <= 1'b0;
            md_is_div_q   <= 1'b0;
            md_done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            alu_control_q <= alu_control_d;
            illegal_q     <= illegal_d;
            md_start_q    <= md_start_d;
            md_is_div_q   <= md_is_div_d;
            md_done_q     <= md_done_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_control = alu_control_q;
    assign illegal     = illegal_q;
    assign md_start    = md_start_q;
    assign md_is_div   = md_is_div_q;
    assign md_done     = md_done_q;

endmodule
